// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage MIPS pipeline: resolves
// memory-wait, load-use and taken-branch hazards and sequences start-up.
module pipeline_hazard_ctrl #(
    parameter int START_DELAY = 2,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        stat_clr,
    output logic        pc_le,
    output logic        if_id_le,
    output logic        id_ex_le,
    output logic        ex_mem_le,
    output logic        mem_wb_le,
    output logic        if_id_clr,
    output logic        id_ex_bubble,
    output logic [15:0] stall_count,
    output logic        mem_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        START    = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // A delay of 0 behaves like 1, so the last hold count is never below 0.
    localparam logic [7:0] DELAY_LAST  = (START_DELAY <= 1) ? 8'd0 : 8'(START_DELAY - 1);
    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] hold_cnt;
    logic [7:0] wait_cnt;
    logic       load_use;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) ||
                       (id_uses_rt && (id_rt == ex_rd)));

    assign state = cur_state;

    always_comb begin
        next_state   = cur_state;
        pc_le        = 1'b0;
        if_id_le     = 1'b0;
        id_ex_le     = 1'b0;
        ex_mem_le    = 1'b0;
        mem_wb_le    = 1'b0;
        if_id_clr    = 1'b0;
        id_ex_bubble = 1'b0;
        case (cur_state)
            START: begin
                id_ex_bubble = 1'b1;
                if (hold_cnt >= DELAY_LAST) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (mem_req && !mem_ready) begin
                    next_state = MEM_WAIT;
                end else if (load_use) begin
                    // The branch (if any) is dropped here and re-resolves next cycle.
                    id_ex_le     = 1'b1;
                    ex_mem_le    = 1'b1;
                    mem_wb_le    = 1'b1;
                    id_ex_bubble = 1'b1;
                end else begin
                    pc_le     = 1'b1;
                    if_id_le  = 1'b1;
                    id_ex_le  = 1'b1;
                    ex_mem_le = 1'b1;
                    mem_wb_le = 1'b1;
                    if_id_clr = branch_taken;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    pc_le      = 1'b1;
                    if_id_le   = 1'b1;
                    id_ex_le   = 1'b1;
                    ex_mem_le  = 1'b1;
                    mem_wb_le  = 1'b1;
                    next_state = RUN;
                end
            end
            default: begin
                id_ex_bubble = 1'b1;
                next_state   = START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= START;
        end else begin
            cur_state <= next_state;
        end
    end

    // Start-up hold counter only advances while frozen in START.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= 8'd0;
        end else if (cur_state == START && hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Wait counter measures the current memory stall; timeout is sticky until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else if (cur_state == MEM_WAIT) begin
            if (mem_ready) begin
                wait_cnt <= 8'd0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
                if ((wait_cnt + 8'd1) == TIMEOUT_VAL) begin
                    mem_timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (stat_clr) begin
            stall_count <= 16'd0;
        end else if (cur_state != START && !pc_le && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl (START_DELAY=2, MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, branch_taken;
    logic        mem_req, mem_ready, stat_clr;
    logic        pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le;
    logic        if_id_clr, id_ex_bubble, mem_timeout;
    logic [15:0] stall_count;
    logic [1:0]  state;
    logic [4:0]  les;

    int checks = 0;
    int passes = 0;

    assign les = {pc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le};

    pipeline_hazard_ctrl #(.START_DELAY(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .stat_clr(stat_clr),
        .pc_le(pc_le), .if_id_le(if_id_le), .id_ex_le(id_ex_le),
        .ex_mem_le(ex_mem_le), .mem_wb_le(mem_wb_le),
        .if_id_clr(if_id_clr), .id_ex_bubble(id_ex_bubble),
        .stall_count(stall_count), .mem_timeout(mem_timeout), .state(state)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; stat_clr = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        #2;
        checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d want 0", state); else passes++;
        checks++; if (les !== 5'b00000) $display("FAIL reset_les got %b want 00000", les); else passes++;
        checks++; if (id_ex_bubble !== 1'b1 || if_id_clr !== 1'b0) $display("FAIL reset_bubble_clr got %b%b want 10", id_ex_bubble, if_id_clr); else passes++;
        checks++; if (stall_count !== 16'd0 || mem_timeout !== 1'b0) $display("FAIL reset_stats got %0d/%b want 0/0", stall_count, mem_timeout); else passes++;
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (state !== 2'd0 || les !== 5'b00000) $display("FAIL start_hold%0d got state %0d les %b want 0 00000", i, state, les); else passes++;
            next_cycle();
        end
        #1;
        checks++; if (state !== 2'd1 || les !== 5'b11111) $display("FAIL start_run got state %0d les %b want 1 11111", state, les); else passes++;
        checks++; if (stall_count !== 16'd0) $display("FAIL start_stall got %0d want 0", stall_count); else passes++;
    endtask

    task automatic test_load_use();
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        #1;
        checks++; if (les !== 5'b00111 || id_ex_bubble !== 1'b1 || if_id_clr !== 1'b0) $display("FAIL lu_rs got les %b bub %b clr %b want 00111 1 0", les, id_ex_bubble, if_id_clr); else passes++;
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (les !== 5'b11111 || id_ex_bubble !== 1'b0) $display("FAIL lu_after got les %b bub %b want 11111 0", les, id_ex_bubble); else passes++;
        checks++; if (stall_count !== 16'd1) $display("FAIL lu_count got %0d want 1", stall_count); else passes++;
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        checks++; if (les !== 5'b11111 || id_ex_bubble !== 1'b0) $display("FAIL lu_r0 got les %b bub %b want 11111 0", les, id_ex_bubble); else passes++;
        ex_rd = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b0;
        #1;
        checks++; if (les !== 5'b11111) $display("FAIL lu_unused_rs got les %b want 11111", les); else passes++;
        ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        #1;
        checks++; if (les !== 5'b00111 || id_ex_bubble !== 1'b1) $display("FAIL lu_rt got les %b bub %b want 00111 1", les, id_ex_bubble); else passes++;
        ex_mem_read = 1'b0;
        #1;
        checks++; if (les !== 5'b11111) $display("FAIL lu_not_load got les %b want 11111", les); else passes++;
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (stall_count !== 16'd1) $display("FAIL lu_count_hold got %0d want 1", stall_count); else passes++;
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        #1;
        checks++; if (les !== 5'b11111 || if_id_clr !== 1'b1 || id_ex_bubble !== 1'b0) $display("FAIL br_alone got les %b clr %b bub %b want 11111 1 0", les, if_id_clr, id_ex_bubble); else passes++;
        next_cycle();
        branch_taken = 1'b0;
        #1;
        checks++; if (if_id_clr !== 1'b0) $display("FAIL br_release got clr %b want 0", if_id_clr); else passes++;
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        #1;
        checks++; if (les !== 5'b00111 || if_id_clr !== 1'b0 || id_ex_bubble !== 1'b1) $display("FAIL br_lu got les %b clr %b bub %b want 00111 0 1", les, if_id_clr, id_ex_bubble); else passes++;
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (stall_count !== 16'd2) $display("FAIL br_lu_count got %0d want 2", stall_count); else passes++;
    endtask

    task automatic test_mem_wait();
        stat_clr = 1'b1;
        next_cycle();
        stat_clr = 1'b0;
        #1;
        checks++; if (stall_count !== 16'd0) $display("FAIL stat_clr got %0d want 0", stall_count); else passes++;
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        checks++; if (state !== 2'd1 || les !== 5'b00000) $display("FAIL mem_req_run got state %0d les %b want 1 00000", state, les); else passes++;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            // Hazard inputs during the wait must not disturb it.
            branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
            #1;
            checks++; if (state !== 2'd2 || les !== 5'b00000) $display("FAIL mem_wait%0d got state %0d les %b want 2 00000", i, state, les); else passes++;
        end
        next_cycle();
        idle_inputs();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        checks++; if (state !== 2'd2 || les !== 5'b11111 || id_ex_bubble !== 1'b0 || if_id_clr !== 1'b0) $display("FAIL mem_ready got state %0d les %b bub %b clr %b want 2 11111 0 0", state, les, id_ex_bubble, if_id_clr); else passes++;
        next_cycle();
        #1;
        checks++; if (state !== 2'd1 || stall_count !== 16'd4) $display("FAIL mem_done got state %0d count %0d want 1 4", state, stall_count); else passes++;
        checks++; if (les !== 5'b11111) $display("FAIL mem_req_ready_run got les %b want 11111", les); else passes++;
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (state !== 2'd1 || stall_count !== 16'd4 || mem_timeout !== 1'b0) $display("FAIL mem_no_stall got state %0d count %0d to %b want 1 4 0", state, stall_count, mem_timeout); else passes++;
    endtask

    task automatic test_timeout();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            #1;
            checks++; if (state !== 2'd2 || mem_timeout !== 1'b0) $display("FAIL to_pre%0d got state %0d to %b want 2 0", i, state, mem_timeout); else passes++;
        end
        next_cycle();
        #1;
        checks++; if (state !== 2'd2 || mem_timeout !== 1'b1) $display("FAIL to_set got state %0d to %b want 2 1", state, mem_timeout); else passes++;
        mem_ready = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        checks++; if (state !== 2'd1 || mem_timeout !== 1'b1) $display("FAIL to_sticky got state %0d to %b want 1 1", state, mem_timeout); else passes++;
        checks++; if (stall_count !== 16'd9) $display("FAIL to_count got %0d want 9", stall_count); else passes++;
        stat_clr = 1'b1;
        next_cycle();
        stat_clr = 1'b0;
        #1;
        checks++; if (stall_count !== 16'd0 || mem_timeout !== 1'b1) $display("FAIL to_statclr got %0d to %b want 0 1", stall_count, mem_timeout); else passes++;
    endtask

    task automatic test_async_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (state !== 2'd2 || stall_count !== 16'd2) $display("FAIL ar_pre got state %0d count %0d want 2 2", state, stall_count); else passes++;
        #1 reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0 || les !== 5'b00000 || id_ex_bubble !== 1'b1 || if_id_clr !== 1'b0) $display("FAIL ar_outputs got state %0d les %b bub %b clr %b want 0 00000 1 0", state, les, id_ex_bubble, if_id_clr); else passes++;
        checks++; if (stall_count !== 16'd0 || mem_timeout !== 1'b0) $display("FAIL ar_stats got %0d to %b want 0 0", stall_count, mem_timeout); else passes++;
        next_cycle();
        idle_inputs();
        next_cycle();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (state !== 2'd0 || les !== 5'b00000) $display("FAIL ar_hold%0d got state %0d les %b want 0 00000", i, state, les); else passes++;
            next_cycle();
        end
        #1;
        checks++; if (state !== 2'd1 || les !== 5'b11111 || stall_count !== 16'd0) $display("FAIL ar_run got state %0d les %b count %0d want 1 11111 0", state, les, stall_count); else passes++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
